// File: rtl/render_pkg.sv
// Shared types and constants for the pixel renderer.
// Colours are RGB 3-3-2.
package render_pkg;

    typedef enum logic [2:0] {
        ST_HOME   = 3'd0,
        ST_UPDATE = 3'd1,
        ST_END    = 3'd2
    } state_e;

    localparam logic [7:0] COL_BLACK  = 8'h00;
    localparam logic [7:0] COL_BLUE   = 8'h03;
    localparam logic [7:0] COL_YELLOW = 8'hFC;
    localparam logic [7:0] COL_RED    = 8'hE0;
    localparam logic [7:0] COL_DKRED  = 8'h20;
    localparam logic [7:0] COL_GREEN  = 8'h1C;
    localparam logic [7:0] COL_WHITE  = 8'hFF;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

    localparam int BOX_X0 = 288;
    localparam int BOX_X1 = 351;
    localparam int BOX_Y0 = 208;
    localparam int BOX_Y1 = 271;

    // Game-object state frozen at frame start
    typedef struct packed {
        logic [2:0]      state;
        logic [7:0]      user_x;
        logic [2:0][7:0] ex;
        logic [2:0][7:0] ey;
        logic [2:0]      alive;
        logic [7:0]      px;
        logic [7:0]      py;
        logic            pv;
    } snap_t;

    // Everything stage 2 needs about one pixel
    typedef struct packed {
        logic       in_range;
        state_e     state;
        logic       blink;
        logic       box;
        logic       proj;
        logic [2:0] enemy;
        logic       player;
    } s1_t;

    // Game units to screen pixels; widened first so 255 maps to 510
    function automatic logic [9:0] to_screen(input logic [7:0] g);
        return {2'b00, g} << 1;
    endfunction

endpackage

// File: rtl/sprite_hit.sv
// Axis-aligned box hit test for one object.
// 11-bit compares so origin + size never wraps.
module sprite_hit #(
    parameter int W = 16,
    parameter int H = 16
) (
    input  logic [9:0] ox,
    input  logic [9:0] oy,
    input  logic [9:0] px,
    input  logic [9:0] py,
    output logic       hit
);

    logic [10:0] x0;
    logic [10:0] y0;
    logic [10:0] x;
    logic [10:0] y;

    // Pixel lies inside [origin, origin + size) on both axes
    always_comb begin
        x0  = {1'b0, ox};
        y0  = {1'b0, oy};
        x   = {1'b0, px};
        y   = {1'b0, py};
        hit = (x >= x0) && (x < x0 + 11'(W)) &&
              (y >= y0) && (y < y0 + 11'(H));
    end

endmodule

// File: rtl/pixel_renderer.sv
// Returns the colour of the requested VGA pixel, two cycles later.
// Object state is frozen at each frame start to avoid tearing.
module pixel_renderer
    import render_pkg::*;
#(
    parameter int SPRITE_W  = 16,
    parameter int PROJ_W    = 4,
    parameter int PROJ_H    = 8,
    parameter int PLAYER_Y  = 448,
    parameter int BLINK_BIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] next_x,
    input  logic [9:0] next_y,
    input  logic [2:0] game_state,
    input  logic [7:0] user_x,
    input  logic [7:0] enemy_x0,
    input  logic [7:0] enemy_x1,
    input  logic [7:0] enemy_x2,
    input  logic [7:0] enemy_y0,
    input  logic [7:0] enemy_y1,
    input  logic [7:0] enemy_y2,
    input  logic [2:0] enemy_alive,
    input  logic [7:0] proj_x,
    input  logic [7:0] proj_y,
    input  logic       proj_valid,
    output logic [7:0] color_out,
    output logic       frame_start
);

    logic       new_frame;
    snap_t      snap_d, snap_q;
    logic [7:0] fc_d, fc_q;
    s1_t        s1_d, s1_q;
    logic [7:0] color_d, color_q;
    logic       hit_player;
    logic       hit_proj;
    logic [2:0] hit_enemy;

    sprite_hit #(.W(SPRITE_W), .H(SPRITE_W)) u_player (
        .ox  (to_screen(snap_q.user_x)),
        .oy  (10'(PLAYER_Y)),
        .px  (next_x),
        .py  (next_y),
        .hit (hit_player)
    );

    for (genvar i = 0; i < 3; i++) begin : g_enemy
        sprite_hit #(.W(SPRITE_W), .H(SPRITE_W)) u_hit (
            .ox  (to_screen(snap_q.ex[i])),
            .oy  (to_screen(snap_q.ey[i])),
            .px  (next_x),
            .py  (next_y),
            .hit (hit_enemy[i])
        );
    end

    sprite_hit #(.W(PROJ_W), .H(PROJ_H)) u_proj (
        .ox  (to_screen(snap_q.px)),
        .oy  (to_screen(snap_q.py)),
        .px  (next_x),
        .py  (next_y),
        .hit (hit_proj)
    );

    // Frame detect: load the snapshot and bump the frame counter
    always_comb begin
        new_frame = (next_x == '0) && (next_y == '0);
        snap_d    = snap_q;
        fc_d      = fc_q;
        if (new_frame) begin
            snap_d.state  = game_state;
            snap_d.user_x = user_x;
            snap_d.ex     = {enemy_x2, enemy_x1, enemy_x0};
            snap_d.ey     = {enemy_y2, enemy_y1, enemy_y0};
            snap_d.alive  = enemy_alive;
            snap_d.px     = proj_x;
            snap_d.py     = proj_y;
            snap_d.pv     = proj_valid;
            fc_d          = fc_q + 8'd1;
        end
    end

    // Stage 1: hit flags plus the state/blink seen by this pixel
    always_comb begin
        s1_d.in_range = (next_x < 10'(H_ACTIVE)) &&
                        (next_y < 10'(V_ACTIVE));
        if (snap_q.state == ST_UPDATE) begin
            s1_d.state = ST_UPDATE;
        end else if (snap_q.state == ST_END) begin
            s1_d.state = ST_END;
        end else begin
            s1_d.state = ST_HOME;
        end
        s1_d.blink  = fc_q[BLINK_BIT];
        s1_d.box    = (next_x >= 10'(BOX_X0)) &&
                      (next_x <= 10'(BOX_X1)) &&
                      (next_y >= 10'(BOX_Y0)) &&
                      (next_y <= 10'(BOX_Y1));
        s1_d.proj   = hit_proj & snap_q.pv;
        s1_d.enemy  = hit_enemy & snap_q.alive;
        s1_d.player = hit_player;
    end

    // Stage 2: priority colour selection
    always_comb begin
        color_d = COL_BLACK;
        if (s1_q.in_range) begin
            unique case (s1_q.state)
                ST_HOME: begin
                    color_d = (s1_q.box && s1_q.blink) ?
                              COL_YELLOW : COL_BLUE;
                end
                ST_UPDATE: begin
                    if (s1_q.proj) begin
                        color_d = COL_WHITE;
                    end else if (|s1_q.enemy) begin
                        color_d = COL_RED;
                    end else if (s1_q.player) begin
                        color_d = COL_GREEN;
                    end else begin
                        color_d = COL_BLACK;
                    end
                end
                ST_END: begin
                    color_d = s1_q.blink ? COL_RED : COL_DKRED;
                end
                default: color_d = COL_BLACK;
            endcase
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            snap_q  <= '0;
            fc_q    <= '0;
            s1_q    <= '0;
            color_q <= '0;
        end else begin
            snap_q  <= snap_d;
            fc_q    <= fc_d;
            s1_q    <= s1_d;
            color_q <= color_d;
        end
    end

    assign color_out   = color_q;
    assign frame_start = new_frame & rst;

endmodule
